// File: rtl/cpu_fetch_prefetch_pkg.sv
// Shared fetch types: queued instruction record, fetch FSM states, opcodes,
// immediate extraction and register-index decode used by the prefetch stage.
package cpu_fetch_prefetch_pkg;

  typedef enum logic [1:0] {FETCH, WAIT_JUMP, WAIT_IRQ} fetch_state_t;

  // Register indices are {fp_bank, index}; zero when the operand is absent.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [5:0]  inst_rs1;
    logic [5:0]  inst_rs2;
    logic [5:0]  inst_rs3;
    logic [5:0]  inst_rd;
    logic        predicted_taken;
  } fetch_pred_t;

  typedef struct packed {
    logic [5:0] rs1;
    logic [5:0] rs2;
    logic [5:0] rs3;
    logic [5:0] rd;
  } reg_idx_t;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_MADD     = 7'b1000011;
  localparam logic [6:0] OPC_MSUB     = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
  localparam logic [6:0] OPC_NMADD    = 7'b1001111;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_WFI   = 32'h1050_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic reg_idx_t decode_regs(input logic [31:0] inst);
    logic h1, h2, h3, hd, f1, f2, f3, fd;
    logic [4:0] f5;
    reg_idx_t r;
    f5 = inst[31:27];
    {h1, h2, h3, hd} = 4'b0000;
    {f1, f2, f3, fd} = 4'b0000;
    case (inst[6:0])
      OPC_OP:                           {h1, h2, hd} = 3'b111;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:   {h1, hd} = 2'b11;
      OPC_STORE, OPC_BRANCH:            {h1, h2} = 2'b11;
      OPC_LUI, OPC_AUIPC, OPC_JAL:      hd = 1'b1;
      OPC_SYSTEM: begin
        hd = (inst[14:12] != 3'b000);
        h1 = (inst[14:12] != 3'b000) && !inst[14];
      end
      OPC_LOAD_FP:                      {h1, hd, fd} = 3'b111;
      OPC_STORE_FP:                     {h1, h2, f2} = 3'b111;
      // Compares, FCVT.W and FMV.X write the integer bank; FCVT.S.W and FMV.W.X read it.
      OPC_OP_FP: begin
        h1 = 1'b1;
        hd = 1'b1;
        f2 = 1'b1;
        h2 = (f5[4:3] == 2'b00) || (f5 == 5'b10100);
        f1 = !((f5[4:3] == 2'b11) && f5[1]);
        fd = !f5[4] || ((f5[4:3] == 2'b11) && f5[1]);
      end
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: {h1, h2, h3, hd, f1, f2, f3, fd} = 8'hFF;
      default: ;
    endcase
    r.rs1 = h1 ? {f1, inst[19:15]} : 6'd0;
    r.rs2 = h2 ? {f2, inst[24:20]} : 6'd0;
    r.rs3 = h3 ? {f3, inst[31:27]} : 6'd0;
    r.rd  = hd ? {fd, inst[11:7]}  : 6'd0;
    return r;
  endfunction

endpackage

// File: rtl/cpu_fetch_prefetch_fifo.sv
// DEPTH-entry synchronous FIFO with wrapping pointers and a clear that
// overrides any same-cycle push or pop; reads as zero while empty.
module cpu_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_sys) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cpu_fetch_prefetch.sv
// Fetch stage: PC generator with static branch prediction feeding a prefetch
// queue between the ICache and decode.
//   state     | meaning
//   FETCH     | request o_icache_pc, push returned words while the queue has room
//   WAIT_JUMP | unpredicted control flow queued; idle until execute flushes
//   WAIT_IRQ  | ECALL/WFI queued; idle until a flush or interrupt dispatch
module cpu_fetch_prefetch
  import cpu_fetch_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          DEPTH        = 4,
  parameter bit          PREDICT      = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_irq_pending,
  input  logic [31:0] i_irq_pc,
  output logic        o_irq_dispatched,
  output logic [31:0] o_irq_epc,
  output logic [31:0] o_icache_pc,
  input  logic        i_icache_ready,
  input  logic [31:0] i_icache_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output fetch_pred_t o_data,
  output logic [31:0] o_starve
);
  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         irq_r, dispatch, fifo_clr;
  logic         push, pop, taken, full, empty;
  fetch_pred_t  push_data, head;
  reg_idx_t     regs;

  assign regs        = decode_regs(i_icache_rdata);
  assign o_valid     = !empty;
  assign o_data      = head;
  assign o_icache_pc = pc;
  // Edge detection only runs where irq_r is tracking, so a deferred edge in
  // WAIT_JUMP is taken once the redirect returns to FETCH.
  assign dispatch    = !i_flush && !irq_r && i_irq_pending && (state != WAIT_JUMP);
  assign fifo_clr    = i_flush || dispatch;
  assign pop         = o_valid && i_ready;
  assign push_data   = '{pc: pc, instruction: i_icache_rdata, inst_rs1: regs.rs1,
                         inst_rs2: regs.rs2, inst_rs3: regs.rs3, inst_rd: regs.rd,
                         predicted_taken: taken};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    taken     = 1'b0;
    if (state == FETCH && i_icache_ready && !full) begin
      push   = 1'b1;
      pc_nxt = pc + 32'd4;
      case (i_icache_rdata[6:0])
        OPC_JAL: begin
          if (PREDICT) begin
            pc_nxt = pc + imm_j(i_icache_rdata);
            taken  = 1'b1;
          end else begin
            pc_nxt    = pc;
            state_nxt = WAIT_JUMP;
          end
        end
        OPC_BRANCH: begin
          if (!PREDICT) begin
            pc_nxt    = pc;
            state_nxt = WAIT_JUMP;
          end else if (i_icache_rdata[31]) begin
            pc_nxt = pc + imm_b(i_icache_rdata);
            taken  = 1'b1;
          end
        end
        OPC_JALR: begin
          pc_nxt    = pc;
          state_nxt = WAIT_JUMP;
        end
        OPC_SYSTEM: begin
          if (i_icache_rdata == INST_MRET) begin
            pc_nxt    = pc;
            state_nxt = WAIT_JUMP;
          end else if (i_icache_rdata == INST_ECALL || i_icache_rdata == INST_WFI) begin
            state_nxt = WAIT_IRQ;
          end
        end
        default: ;
      endcase
    end
    if (dispatch) begin
      pc_nxt    = i_irq_pc;
      state_nxt = FETCH;
    end
    if (i_flush) begin
      pc_nxt    = i_flush_pc;
      state_nxt = FETCH;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= FETCH;
      pc               <= RESET_VECTOR;
      irq_r            <= 1'b0;
      o_irq_dispatched <= 1'b0;
      o_irq_epc        <= '0;
      o_starve         <= '0;
    end else begin
      state            <= state_nxt;
      pc               <= pc_nxt;
      o_irq_dispatched <= dispatch;
      if (state != WAIT_JUMP) irq_r <= i_irq_pending;
      if (dispatch) o_irq_epc <= empty ? pc : head.pc;
      if (i_ready && !o_valid) o_starve <= o_starve + 32'd1;
    end
  end

  cpu_fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_pred_t))) u_fifo (
    .clk_sys (i_clock),
    .rst     (i_reset),
    .clr     (fifo_clr),
    .push    (push),
    .pop     (pop),
    .wdata   (push_data),
    .rdata   (head),
    .full    (full),
    .empty   (empty)
  );
endmodule

// File: tb/tb_cpu_fetch_prefetch.sv
// Directed bench: a predicting and a non-predicting instance share stimulus
// and a fixed instruction memory; a vector table plus hand-written sequences.
module tb_cpu_fetch_prefetch;
  import cpu_fetch_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, irq, icr, rdy;
  logic [31:0] flush_pc, irq_pc, icache_rdata;

  logic        valid, irq_disp, np_valid, np_irq_disp;
  logic [31:0] icache_pc, irq_epc, starve, np_icache_pc, np_irq_epc, np_starve;
  fetch_pred_t data, np_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_fetch_prefetch #(.RESET_VECTOR(32'h0), .DEPTH(4), .PREDICT(1'b1)) dut (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .i_flush_pc(flush_pc),
    .i_irq_pending(irq), .i_irq_pc(irq_pc), .o_irq_dispatched(irq_disp),
    .o_irq_epc(irq_epc), .o_icache_pc(icache_pc), .i_icache_ready(icr),
    .i_icache_rdata(icache_rdata), .o_valid(valid), .i_ready(rdy),
    .o_data(data), .o_starve(starve)
  );

  cpu_fetch_prefetch #(.RESET_VECTOR(32'h0), .DEPTH(4), .PREDICT(1'b0)) dut_np (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .i_flush_pc(flush_pc),
    .i_irq_pending(irq), .i_irq_pc(irq_pc), .o_irq_dispatched(np_irq_disp),
    .o_irq_epc(np_irq_epc), .o_icache_pc(np_icache_pc), .i_icache_ready(icr),
    .i_icache_rdata(icache_rdata), .o_valid(np_valid), .i_ready(rdy),
    .o_data(np_data), .o_starve(np_starve)
  );

  // 0x200 beq x0,x0,-16; 0x600 jal x1,+32; 0x700 wfi; 0x900 add x3,x1,x2; 0xA00 jalr x0,0(x1)
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h200: return 32'hFE0008E3;
      32'h600: return 32'h020000EF;
      32'h700: return 32'h10500073;
      32'h900: return 32'h002081B3;
      32'hA00: return 32'h00008067;
      default: return 32'h00000013;
    endcase
  endfunction

  assign icache_rdata = imem(icache_pc);

  typedef struct {
    logic        f;
    logic [31:0] fpc;
    logic        icr;
    logic        rdy;
    logic        v;
    logic [31:0] hpc;
    logic        tk;
    logic [31:0] ipc;
    logic        nv;
    logic [31:0] nipc;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];

  function automatic vec_t mk(logic f, logic [31:0] fpc, logic ic, logic rd, logic v,
                              logic [31:0] hpc, logic tk, logic [31:0] ipc,
                              logic nv, logic [31:0] nipc);
    vec_t r;
    r.f = f; r.fpc = fpc; r.icr = ic; r.rdy = rd; r.v = v; r.hpc = hpc;
    r.tk = tk; r.ipc = ipc; r.nv = nv; r.nipc = nipc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    // straight-line at 0x100
    vecs[0]  = mk(1, 32'h100, 0, 1, 0, 0,       0, 32'h100, 0, 32'h100);
    vecs[1]  = mk(0, 0,       1, 1, 1, 32'h100, 0, 32'h104, 1, 32'h104);
    vecs[2]  = mk(0, 0,       1, 1, 1, 32'h104, 0, 32'h108, 1, 32'h108);
    vecs[3]  = mk(0, 0,       1, 1, 1, 32'h108, 0, 32'h10C, 1, 32'h10C);
    // decode stalled: four pushes then hold at 0x110, then drain in order
    vecs[4]  = mk(1, 32'h100, 1, 0, 0, 0,       0, 32'h100, 0, 32'h100);
    vecs[5]  = mk(0, 0,       1, 0, 1, 32'h100, 0, 32'h104, 1, 32'h104);
    vecs[6]  = mk(0, 0,       1, 0, 1, 32'h100, 0, 32'h108, 1, 32'h108);
    vecs[7]  = mk(0, 0,       1, 0, 1, 32'h100, 0, 32'h10C, 1, 32'h10C);
    vecs[8]  = mk(0, 0,       1, 0, 1, 32'h100, 0, 32'h110, 1, 32'h110);
    vecs[9]  = mk(0, 0,       1, 0, 1, 32'h100, 0, 32'h110, 1, 32'h110);
    vecs[10] = mk(0, 0,       1, 0, 1, 32'h100, 0, 32'h110, 1, 32'h110);
    vecs[11] = mk(0, 0,       1, 1, 1, 32'h104, 0, 32'h110, 1, 32'h110);
    vecs[12] = mk(0, 0,       1, 1, 1, 32'h108, 0, 32'h114, 1, 32'h114);
    vecs[13] = mk(0, 0,       1, 1, 1, 32'h10C, 0, 32'h118, 1, 32'h118);
    vecs[14] = mk(0, 0,       1, 1, 1, 32'h110, 0, 32'h11C, 1, 32'h11C);
    // backward BEQ: predicted to 0x1F0; non-predicting copy waits for flush to 0x204
    vecs[15] = mk(1, 32'h200, 0, 1, 0, 0,       0, 32'h200, 0, 32'h200);
    vecs[16] = mk(0, 0,       1, 1, 1, 32'h200, 1, 32'h1F0, 1, 32'h200);
    vecs[17] = mk(0, 0,       1, 1, 1, 32'h1F0, 0, 32'h1F4, 0, 32'h200);
    vecs[18] = mk(1, 32'h204, 0, 1, 0, 0,       0, 32'h204, 0, 32'h204);
    vecs[19] = mk(0, 0,       1, 1, 1, 32'h204, 0, 32'h208, 1, 32'h208);
    // JAL at 0x600 followed without a bubble
    vecs[20] = mk(1, 32'h5FC, 0, 1, 0, 0,       0, 32'h5FC, 0, 32'h5FC);
    vecs[21] = mk(0, 0,       1, 1, 1, 32'h5FC, 0, 32'h600, 1, 32'h600);
    vecs[22] = mk(0, 0,       1, 1, 1, 32'h600, 1, 32'h620, 1, 32'h600);
    vecs[23] = mk(0, 0,       1, 1, 1, 32'h620, 0, 32'h624, 0, 32'h600);
    // flush a full queue 0x300..0x30C to 0x400
    vecs[24] = mk(1, 32'h300, 0, 0, 0, 0,       0, 32'h300, 0, 32'h300);
    vecs[25] = mk(0, 0,       1, 0, 1, 32'h300, 0, 32'h304, 1, 32'h304);
    vecs[26] = mk(0, 0,       1, 0, 1, 32'h300, 0, 32'h308, 1, 32'h308);
    vecs[27] = mk(0, 0,       1, 0, 1, 32'h300, 0, 32'h30C, 1, 32'h30C);
    vecs[28] = mk(0, 0,       1, 0, 1, 32'h300, 0, 32'h310, 1, 32'h310);
    vecs[29] = mk(1, 32'h400, 1, 1, 0, 0,       0, 32'h400, 0, 32'h400);
    vecs[30] = mk(0, 0,       1, 1, 1, 32'h400, 0, 32'h404, 1, 32'h404);

    rst = 1'b1; flush = 1'b0; flush_pc = '0; irq = 1'b0; irq_pc = 32'h800;
    icr = 1'b0; rdy = 1'b0;
    tick(); tick();
    chk("rst valid", valid, 0);
    chk("rst icache_pc", icache_pc, 32'h0);
    chk("rst data.pc", data.pc, 0);
    chk("rst data.instruction", data.instruction, 0);
    chk("rst irq_disp", irq_disp, 0);
    chk("rst irq_epc", irq_epc, 0);
    chk("rst starve", starve, 0);

    // starvation counter
    rst = 1'b0; rdy = 1'b1;
    repeat (5) tick();
    chk("starve 5", starve, 5);
    chk("np starve 5", np_starve, 5);
    icr = 1'b1;
    tick();
    chk("starve push", starve, 6);
    chk("starve push valid", valid, 1);
    tick();
    chk("starve held", starve, 6);

    for (int i = 0; i < NV; i++) begin
      flush = vecs[i].f; flush_pc = vecs[i].fpc; icr = vecs[i].icr; rdy = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d valid", i), valid, vecs[i].v);
      if (vecs[i].v) begin
        chk($sformatf("v%0d head_pc", i), data.pc, vecs[i].hpc);
        chk($sformatf("v%0d taken", i), data.predicted_taken, vecs[i].tk);
      end
      chk($sformatf("v%0d icache_pc", i), icache_pc, vecs[i].ipc);
      chk($sformatf("v%0d np_valid", i), np_valid, vecs[i].nv);
      if (vecs[i].nv) chk($sformatf("v%0d np_head_pc", i), np_data.pc, vecs[i].hpc);
      chk($sformatf("v%0d np_icache_pc", i), np_icache_pc, vecs[i].nipc);
    end
    flush = 1'b0;

    // JALR parks fetch at its own pc until a flush
    flush = 1'b1; flush_pc = 32'hA00; icr = 1'b0; rdy = 1'b0;
    tick();
    flush = 1'b0; icr = 1'b1;
    tick(); tick();
    chk("jalr head", data.pc, 32'hA00);
    chk("jalr icache_pc", icache_pc, 32'hA00);
    rdy = 1'b1;
    tick();
    chk("jalr single entry", valid, 0);

    // interrupt with head 0x508
    flush = 1'b1; flush_pc = 32'h508; icr = 1'b0; rdy = 1'b0;
    tick();
    flush = 1'b0; icr = 1'b1;
    tick(); tick();
    irq = 1'b1;
    tick();
    chk("irq disp", irq_disp, 1);
    chk("irq epc", irq_epc, 32'h508);
    chk("irq valid", valid, 0);
    chk("irq icache_pc", icache_pc, 32'h800);
    chk("np irq disp", np_irq_disp, 1);
    chk("np irq epc", np_irq_epc, 32'h508);
    icr = 1'b0;
    tick();
    chk("irq pulse end", irq_disp, 0);
    chk("irq pc held", icache_pc, 32'h800);

    // WFI, then interrupt from WAIT_IRQ
    irq = 1'b0; flush = 1'b1; flush_pc = 32'h700;
    tick();
    flush = 1'b0; icr = 1'b1;
    tick(); tick();
    chk("wfi head", data.pc, 32'h700);
    chk("wfi valid", valid, 1);
    irq = 1'b1;
    tick();
    chk("wfi irq disp", irq_disp, 1);
    chk("wfi irq epc", irq_epc, 32'h700);
    chk("wfi irq icache_pc", icache_pc, 32'h800);
    chk("wfi irq valid", valid, 0);
    tick();
    chk("wfi handler head", data.pc, 32'h800);
    chk("wfi pulse end", irq_disp, 0);
    irq = 1'b0;

    // 32-bit wrap
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC; icr = 1'b0;
    tick();
    flush = 1'b0; icr = 1'b1;
    tick();
    chk("wrap head", data.pc, 32'hFFFF_FFFC);
    chk("wrap icache_pc", icache_pc, 32'h0);

    // register fields, then reset with a full queue
    flush = 1'b1; flush_pc = 32'h900; icr = 1'b0;
    tick();
    flush = 1'b0; icr = 1'b1;
    repeat (5) tick();
    chk("add instruction", data.instruction, 32'h002081B3);
    chk("add rs1", data.inst_rs1, 1);
    chk("add rs2", data.inst_rs2, 2);
    chk("add rs3", data.inst_rs3, 0);
    chk("add rd", data.inst_rd, 3);
    chk("full hold", icache_pc, 32'h910);
    rst = 1'b1;
    tick();
    chk("midrst valid", valid, 0);
    chk("midrst icache_pc", icache_pc, 32'h0);
    chk("midrst starve", starve, 0);
    rst = 1'b0; icr = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
